reg_bank_arbiter: RTL

Shares the single-port configuration register bank between several requesters, for example the SPI register interface and on-chip masters, using a round-robin req/ack handshake.
- Owns the config register storage; drives config_regs directly.
- Serves read-only status words from a second address space.
- Sits between the serial front end and the core logic; replaces direct register writes from the SPI side.

---
 rtl/reg_bank_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/reg_bank_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the arbitrated configuration register bank.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    // Index width inside one bank; never narrower than one bit.
    function automatic int unsigned calc_addr_w(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    // The bank-select flag sits directly above the bank index.
    function automatic int unsigned status_sel_bit(input int unsigned addr_w);
        return addr_w;
    endfunction

    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned STATUS_SEL   = status_sel_bit(calc_addr_w(DEF_NUM_REGS));

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    // Scan N positions starting one past the last winner.
    always_comb begin
        int unsigned cand;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(ptr) + i) % N;
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Config register bank shared between requesters via a round-robin
// req/ack handshake; also serves read-only status words.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ADDR_W   = calc_addr_w(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*(ADDR_W+1)-1:0] addr,
    input  logic [NUM_REQ*WIDTH-1:0]      wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic [WIDTH-1:0]              rdata,
    output logic                          busy,
    input  logic [NUM_REGS*WIDTH-1:0]     status_in,
    output logic [NUM_REGS*WIDTH-1:0]     config_regs
);

    localparam int unsigned IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AW1 = ADDR_W + 1;
    localparam int unsigned SEL = status_sel_bit(ADDR_W);

    state_t             state_q, state_d;
    logic [IW-1:0]      gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic [WIDTH-1:0]   mem_q [NUM_REGS];
    logic [WIDTH-1:0]   mem_d [NUM_REGS];

    logic               arb_valid;
    logic [IW-1:0]      arb_idx;

    logic               sel_we;
    logic [AW1-1:0]     sel_addr;
    logic [WIDTH-1:0]   sel_wdata;
    logic [ADDR_W-1:0]  sel_index;
    logic               sel_status;
    logic               sel_in_range;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (IW)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    // Pick out the granted requester's command fields.
    always_comb begin
        sel_we       = we[gnt_idx_q];
        sel_addr     = addr[32'(gnt_idx_q)*AW1 +: AW1];
        sel_wdata    = wdata[32'(gnt_idx_q)*WIDTH +: WIDTH];
        sel_index    = sel_addr[ADDR_W-1:0];
        sel_status   = sel_addr[SEL];
        sel_in_range = (32'(sel_index) < NUM_REGS);
    end

    // Next-state, access execution and completion pulse.
    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        mem_d     = mem_q;
        case (state_q)
            IDLE: begin
                if (ena && arb_valid) begin
                    gnt_idx_d = arb_idx;
                    rr_ptr_d  = arb_idx;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                // rdata takes the pre-write contents (read-before-write).
                if (!sel_in_range) begin
                    rdata_d = '0;
                end else if (sel_status) begin
                    rdata_d = status_in[32'(sel_index)*WIDTH +: WIDTH];
                end else begin
                    rdata_d = mem_q[sel_index];
                end
                if (sel_we && !sel_status && sel_in_range) begin
                    mem_d[sel_index] = sel_wdata;
                end
                ack_d[gnt_idx_q] = 1'b1;
                state_d          = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, storage and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= IW'(NUM_REQ - 1);
            ack_q     <= '0;
            rdata_q   <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            mem_q     <= mem_d;
        end
    end

    // Flatten storage onto the config bus.
    always_comb begin
        config_regs = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            config_regs[k*WIDTH +: WIDTH] = mem_q[k];
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign busy  = (state_q == GRANT) || (state_q == ACK);

endmodule
